// File: rtl/audio_frame_scheduler.sv
// audio_frame_scheduler: per-frame req/ack poll of N_SRC voices, saturating signed mix to one I2S sample
module audio_frame_scheduler #(
    parameter int N_SRC = 4,
    parameter int DW = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic [N_SRC-1:0]    src_en,
    input  logic [N_SRC-1:0]    src_ack,
    input  logic [N_SRC*DW-1:0] src_data,
    input  logic                err_clr,
    output logic [N_SRC-1:0]    src_req,
    output logic [DW-1:0]       sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                overrun,
    output logic [N_SRC-1:0]    timeout_err
);
    localparam int IW = N_SRC > 1 ? $clog2(N_SRC) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int AW = DW + $clog2(N_SRC);
    localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [TW-1:0] timer, timer_n;
    logic signed [AW-1:0] acc, acc_n;
    logic signed [DW-1:0] slice;
    logic [N_SRC-1:0] req_n, err_n;
    logic [DW-1:0] out_n;
    logic valid_n, ovr_n, adv, last;
    assign slice = src_data[idx*DW +: DW];
    assign last = idx == IW'(N_SRC - 1);
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        idx_n = idx;
        timer_n = timer;
        acc_n = acc;
        req_n = src_req;
        out_n = sample_out;
        valid_n = 1'b0;
        ovr_n = frame_tick && state != IDLE;
        err_n = err_clr ? '0 : timeout_err;
        adv = 1'b0;
        case (state)
            IDLE: if (frame_tick) begin
                acc_n = '0;
                idx_n = '0;
                state_n = SCAN;
            end
            SCAN: if (src_en[idx]) begin
                req_n = '0;
                req_n[idx] = 1'b1;
                timer_n = '0;
                state_n = WAIT;
            end else adv = 1'b1;
            WAIT: begin
                // ack takes priority over a timeout landing on the same edge
                adv = src_ack[idx] || timer == TW'(ACK_TIMEOUT - 1);
                if (src_ack[idx]) acc_n = acc + AW'(slice);
                else if (adv) err_n[idx] = 1'b1;
                else timer_n = timer + TW'(1);
            end
            DONE: begin
                out_n = acc > SMAX ? SMAX[DW-1:0] : acc < SMIN ? SMIN[DW-1:0] : acc[DW-1:0];
                valid_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (adv) begin
            req_n = '0;
            state_n = last ? DONE : SCAN;
            idx_n = last ? idx : idx + IW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            timer <= '0;
            acc <= '0;
            src_req <= '0;
            sample_out <= '0;
            sample_valid <= 1'b0;
            overrun <= 1'b0;
            timeout_err <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            timer <= timer_n;
            acc <= acc_n;
            src_req <= req_n;
            sample_out <= out_n;
            sample_valid <= valid_n;
            overrun <= ovr_n;
            timeout_err <= err_n;
        end
    end
endmodule
